// File: rtl/bram_dump_tx.sv
// bram_dump_tx: reads BRAM addresses 0..LAST_ADDR in order and sends each byte
// on a UART tx line as 8N1. A one-cycle start pulse launches a dump.
// Optional macro BRAM_DUMP_HEX_EN: send each byte as two uppercase ASCII hex
// characters (high nibble first) instead of one raw byte.
//
// Handshake: start is a single-cycle request, accepted only when the block is
// idle and not in its done cycle; otherwise it is dropped, never queued.
// bram_dout is expected one cycle after the cycle in which bram_en is high.
module bram_dump_tx #(
  parameter int ADDR_W       = 10,
  parameter int LAST_ADDR    = 1023,
  parameter int CLKS_PER_BIT = 278
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

`ifdef BRAM_DUMP_HEX_EN
  // Low nibble waits here while the high-nibble character is on the line.
  logic [3:0] lo_q;
  logic       second;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  // Dump sequencer: read, latch, then shift each frame out bit by bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
`ifdef BRAM_DUMP_HEX_EN
      lo_q      <= '0;
      second    <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      bram_en <= 1'b0;
      case (state)
        IDLE: begin
          // A start landing on the done cycle belongs to the finished dump.
          if (start && !done) begin
            state     <= READ;
            busy      <= 1'b1;
            bram_en   <= 1'b1;
            bram_addr <= '0;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
`ifdef BRAM_DUMP_HEX_EN
          shift  <= hex_char(bram_dout[7:4]);
          lo_q   <= bram_dout[3:0];
          second <= 1'b0;
`else
          shift  <= bram_dout;
`endif
          bit_idx <= '0;
          cnt     <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef BRAM_DUMP_HEX_EN
            // Second character goes straight out; no new BRAM read needed.
            if (!second) begin
              shift   <= hex_char(lo_q);
              second  <= 1'b1;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else
`endif
            if (bram_addr == ADDR_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bram_addr <= bram_addr + 1'b1;
              bram_en   <= 1'b1;
              state     <= READ;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_dump_tx.sv
// Bench for bram_dump_tx: cycle-level expected waveform built from the frame
// rules, an independent UART receiver, and literal checks on the first dump.
module tb_bram_dump_tx;

  localparam int ADDR_W = 4;
  localparam int LAST   = 3;
  localparam int CPB    = 4;
`ifdef BRAM_DUMP_HEX_EN
  localparam int NCH = 2;
`else
  localparam int NCH = 1;
`endif
  localparam int DUMP_CYC = (LAST + 1) * (2 + NCH * 10 * CPB);

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_dout = 8'h00;
  logic              tx, busy, done;

  always #5 clk = ~clk;

  bram_dump_tx #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .tx(tx), .busy(busy), .done(done)
  );

  // BRAM model with one-cycle read latency
  logic [7:0] mem [16];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          nprint = 0;
  bit          chk_en = 1'b0;
  bit          was_idle = 1'b1;
  logic [3:0]  last_addr = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [3:0]  addr_log[$];
  int          cyc = 0;
  int          first_read = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  // k-th UART character sent for BRAM byte v
  function automatic logic [7:0] char_of(input logic [7:0] v, input int k);
    if (NCH == 2) return hexc(k == 0 ? v[7:4] : v[3:0]);
    return v;
  endfunction

  function automatic logic [7:0] pk(input logic t, input logic b, input logic e,
                                    input logic d, input logic [3:0] ad);
    return {t, b, e, d, ad};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole dump as a per-cycle list of {tx,busy,bram_en,done,bram_addr}.
  task automatic push_dump();
    logic [7:0] ch;
    logic       bitv;
    for (int a = 0; a <= LAST; a++) begin
      exp_q.push_back(pk(1'b1, 1'b1, 1'b1, 1'b0, a[3:0]));
      exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 1'b0, a[3:0]));
      for (int k = 0; k < NCH; k++) begin
        ch = char_of(mem[a], k);
        for (int b = 0; b < 10; b++) begin
          bitv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
          repeat (CPB) exp_q.push_back(pk(bitv, 1'b1, 1'b0, 1'b0, a[3:0]));
        end
      end
    end
    exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, LAST[3:0]));
    last_addr = LAST[3:0];
  endtask

  // Model acceptance: a start is taken only if the previous cycle was idle.
  always @(posedge clk) begin
    if (chk_en && rst_n && start && was_idle) push_dump();
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [7:0] ev, av;
    if (chk_en) begin
      cyc++;
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        was_idle = 1'b0;
      end else begin
        ev = pk(1'b1, 1'b0, 1'b0, 1'b0, last_addr);
        was_idle = 1'b1;
      end
      av = {tx, busy, bram_en, done, bram_addr};
      checks++;
      if (av !== ev) begin
        errors++;
        if (nprint < 10)
          $display("FAIL cycle %0d {tx,busy,en,done,addr}: got %b expected %b", cyc, av, ev);
        nprint++;
      end
      if (bram_en) begin
        addr_log.push_back(bram_addr);
        if (bram_addr == 4'd0) first_read = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Independent UART receiver sampling mid-bit
  logic [7:0] rx_byte;
  always begin
    @(negedge clk);
    if (chk_en && rst_n && tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      check("rx_start_bit", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_byte[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      check("rx_stop_bit", {31'd0, tx}, 32'd1);
      rx_q.push_back(rx_byte);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic clear_logs();
    rx_q.delete();
    addr_log.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input bit poke);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check("done_within_budget", {31'd0, seen}, 32'd1);
    if (seen && poke) begin
      start = 1'b1;          // lands on the done cycle: must be dropped
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic check_dump(input string tag);
    int idx;
    repeat (12) @(posedge clk);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_latency"}, done_cyc - first_read, DUMP_CYC);
    check({tag, "_model_drained"}, exp_q.size(), 0);
    check({tag, "_rx_count"}, rx_q.size(), (LAST + 1) * NCH);
    check({tag, "_addr_count"}, addr_log.size(), LAST + 1);
    for (int a = 0; a <= LAST; a++) begin
      check({tag, "_addr_seq"}, (a < addr_log.size()) ? {28'd0, addr_log[a]} : 32'hx, a);
      for (int k = 0; k < NCH; k++) begin
        idx = a * NCH + k;
        check({tag, "_rx_char"}, (idx < rx_q.size()) ? {24'd0, rx_q[idx]} : 32'hx,
              {24'd0, char_of(mem[a], k)});
      end
    end
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] lit_raw[4] = '{8'h55, 8'hA0, 8'h01, 8'hFF};
  logic [7:0] lit_hex[8] = '{8'h35, 8'h35, 8'h41, 8'h30, 8'h30, 8'h31, 8'h46, 8'h46};

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h55; mem[1] = 8'hA0; mem[2] = 8'h01; mem[3] = 8'hFF;

    // reset and idle
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (20) @(posedge clk);
    check("idle_done_count", done_cnt, 0);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // first dump with hand-computed expectations
    clear_logs();
    pulse_start();
    wait_done(1'b0);
    check_dump("dump1");
    check("dump1_latency_literal", done_cyc - first_read, (NCH == 2) ? 328 : 168);
    for (int i = 0; i < 4 * NCH; i++)
      check("dump1_rx_literal", (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hx,
            {24'd0, (NCH == 2) ? lit_hex[i] : lit_raw[i]});

    // second start 50 cycles into the dump is ignored
    clear_logs();
    pulse_start();
    repeat (50) @(posedge clk);
    pulse_start();
    wait_done(1'b0);
    check_dump("restart_ignored");

    // asynchronous reset mid-frame
    clear_logs();
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    last_addr = '0;
    #1;
    check("reset_tx_immediate", {31'd0, tx}, 32'd1);
    check("reset_busy_immediate", {31'd0, busy}, 32'd0);
    check("reset_en_immediate", {31'd0, bram_en}, 32'd0);
    check("reset_addr_immediate", {28'd0, bram_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    check("reset_no_done", done_cnt, 0);
    clear_logs();
    pulse_start();
    wait_done(1'b0);
    check_dump("after_reset");

    // randomized contents, idle gaps, spurious starts, start on done cycle
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a <= LAST; a++) mem[a] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 15)) @(posedge clk);
      clear_logs();
      pulse_start();
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        repeat ($urandom_range(5, 60)) @(posedge clk);
        pulse_start();
      end
      wait_done(it[0]);
      check_dump("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_dump_tx.md
# bram_dump_tx

Serialises the contents of the on-chip block RAM onto the board UART `tx` line, one byte per address, from address 0 up to `LAST_ADDR`. It sits directly downstream of the BRAM stage in `top`. It drives the RAM's read port, captures each byte after the RAM's one-cycle read latency, and shifts it out as 8N1. A single-cycle `start` pulse launches a dump; in `top` that pulse comes from the debounced button on W1B[7].

## Interface
- `ADDR_W`, 10: BRAM address width.
- `LAST_ADDR`, 1023: final address dumped, inclusive. Must be less than 2^ADDR_W.
- `CLKS_PER_BIT`, 278: clock cycles per UART bit. 32 MHz / 115200 baud. Minimum 2.

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to begin a dump; ignored while `busy`=1.
- `bram_en`  out  1: BRAM read enable.
- `bram_addr`  out  ADDR_W: BRAM read address.
- `bram_dout`  in  8: BRAM read data, valid one cycle after the `bram_en` cycle.
- `tx`  out  1: UART serial output, idle high.
- `busy`  out  1: high from the first READ cycle until the last stop bit ends.
- `done`  out  1: one-cycle pulse when the dump completes.

## Operation
- FSM states: IDLE, READ, LATCH, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0. `start`=1 → READ with addr=0.
- READ (1 cycle): `bram_en`=1, `bram_addr`=addr → LATCH.
- LATCH (1 cycle): shift register ← `bram_dout`, bit index ← 0 → START.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first; after bit 7 → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then:
  - if addr==LAST_ADDR: `done`=1 for one cycle, `busy`=0 in that same cycle → IDLE;
  - else addr+1 → READ.
- Address counter: ADDR_W bits. It never wraps within a dump; the dump terminates at LAST_ADDR.
- `start` asserted while `busy`=1 is dropped, not queued. `start` asserted in the `done` cycle is also dropped.
- `bram_en` is 0 in every state except READ. `bram_addr` holds its last value otherwise.
- Reset (asynchronous, including mid-frame):
  - `tx`=1, `busy`=0, `done`=0, `bram_en`=0, `bram_addr`=0, state IDLE;
  - any partial frame is abandoned immediately.

## Timing
- `start` sampled high at edge N: READ in cycle N+1 (`busy`=1, `bram_en`=1, addr 0). LATCH in N+2. Start bit begins at N+3.
- Per byte (raw mode): 2 + 10·CLKS_PER_BIT cycles, READ through the end of STOP.
- Total dump: (LAST_ADDR+1)·(2 + 10·CLKS_PER_BIT) cycles from first READ to the `done` cycle. `done` occurs in the cycle after the final stop bit.
- Back-to-back bytes: between one stop bit and the next start bit, `tx` stays high for exactly 2 extra cycles (READ, LATCH).

## Configuration
- `BRAM_DUMP_HEX_EN` defined:
  - each byte is sent as two ASCII uppercase hex characters, high nibble first;
  - e.g. 0x3A → 0x33 '3' then 0x41 'A';
  - the FSM runs START/DATA/STOP twice per BRAM read, with no READ/LATCH between the two characters;
  - per byte: 2 + 20·CLKS_PER_BIT cycles.
- Not defined: raw binary, one UART frame per byte. No hex-conversion logic is synthesised.

## Test plan
Bench parameters: CLKS_PER_BIT=4, ADDR_W=4, LAST_ADDR=3, BRAM model preloaded with 0x55, 0xA0, 0x01, 0xFF.
- Reset, then idle 20 cycles → `tx`=1, `busy`=0, `bram_en`=0, `done` never asserted.
- One-cycle `start` (raw mode):
  - bytes decoded from `tx` are 0x55, 0xA0, 0x01, 0xFF in order;
  - `bram_addr` sequence is 0,1,2,3;
  - `done` pulses once, exactly 4·42=168 cycles after the first READ.
- Second `start` pulse 50 cycles into the dump → ignored; exactly 4 bytes are sent and `done` pulses once.
- `rst_n` low during DATA of byte 1 → `tx`=1 immediately, without waiting for a clock edge; `busy`=0. A fresh `start` after release sends the full dump from address 0.
- With `BRAM_DUMP_HEX_EN`, one `start` → UART characters "55A001FF" (8 frames); `done` 4·82=328 cycles after the first READ.
- Bit-timing check: every `tx` bit level is held for exactly 4 cycles; start bit is 0, stop bit is 1.
